// File: rtl/oneapi_avs_to_axs_pixel_gasket.sv
// Avalon-ST pixel sink to AXI4-Stream pixel source with channel repack, empty masking and a 2-entry skid buffer.
// Optional build macro AVS_TO_AXS_SATURATE_EN: saturate channels whose dropped upper bits are non-zero.
module oneapi_avs_to_axs_pixel_gasket #(
  parameter int PARALLEL_PIXELS     = 4,
  parameter int BITS_PER_CHANNEL    = 12,
  parameter int CHANNELS            = 3,
  parameter int BITS_PER_CHANNEL_AV = 1 << $clog2(BITS_PER_CHANNEL),
  parameter int BITS_PER_PIXEL_AV   = BITS_PER_CHANNEL_AV * CHANNELS,
  parameter int BITS_AV             = BITS_PER_PIXEL_AV * PARALLEL_PIXELS,
  parameter int EMPTY_BITS          = $clog2(BITS_AV / 8),
  parameter int BITS_PER_PIXEL_AXI  = 8 * ((CHANNELS * BITS_PER_CHANNEL + 7) / 8),
  parameter int BITS_AXI            = BITS_PER_PIXEL_AXI * PARALLEL_PIXELS,
  parameter int TUSER_BITS          = (BITS_AXI + 7) / 8
) (
  input  logic                  csi_clk,
  input  logic                  rsi_reset,
  output logic                  asi_ready,
  input  logic                  asi_valid,
  input  logic [BITS_AV-1:0]    asi_data,
  input  logic                  asi_startofpacket,
  input  logic                  asi_endofpacket,
  input  logic [EMPTY_BITS-1:0] asi_empty,
  input  logic                  axm_tready,
  output logic                  axm_tvalid,
  output logic [BITS_AXI-1:0]   axm_tdata,
  output logic                  axm_tlast,
  output logic [TUSER_BITS-1:0] axm_tuser
);

  // state     | meaning
  // ST_IDLE   | between packets; beats without sop are accepted and discarded
  // ST_IN_PKT | inside a packet; every accepted beat is forwarded
  typedef enum logic {ST_IDLE, ST_IN_PKT} state_t;

  localparam int DROP_BITS = BITS_PER_CHANNEL_AV - BITS_PER_CHANNEL;
  localparam int NUM_CH    = PARALLEL_PIXELS * CHANNELS;

  state_t                state_q, state_d;
  logic                  asi_ready_q, asi_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [BITS_AXI-1:0]   out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  out_sop_q, out_sop_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [BITS_AXI-1:0]   skid_data_q, skid_data_d;
  logic                  skid_last_q, skid_last_d;
  logic                  skid_sop_q, skid_sop_d;

  logic                  acc;
  logic                  fwd;
  logic                  drain;
  int                    pix_invalid;
  logic [NUM_CH-1:0]     chan_hi;
  logic [BITS_AXI-1:0]   beat_axi;

  // Repack every channel; pixels counted from the top of an eop beat by asi_empty are zeroed.
  always_comb begin
    logic [BITS_PER_CHANNEL-1:0] chan_val;
    chan_val    = '0;
    beat_axi    = '0;
    chan_hi     = '0;
    pix_invalid = asi_endofpacket ? (int'(asi_empty) * 8) / BITS_PER_PIXEL_AV : 0;
    for (int p = 0; p < PARALLEL_PIXELS; p++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        chan_hi[p*CHANNELS + c] =
          |asi_data[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV + BITS_PER_CHANNEL +: DROP_BITS];
`ifdef AVS_TO_AXS_SATURATE_EN
        chan_val = chan_hi[p*CHANNELS + c] ? '1
                   : asi_data[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL];
`else
        chan_val = asi_data[p*BITS_PER_PIXEL_AV + c*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL];
`endif
        if (p < PARALLEL_PIXELS - pix_invalid) begin
          beat_axi[p*BITS_PER_PIXEL_AXI + c*BITS_PER_CHANNEL +: BITS_PER_CHANNEL] = chan_val;
        end
      end
    end
  end

`ifndef AVS_TO_AXS_SATURATE_EN
  logic unused_chan_hi;
  assign unused_chan_hi = |chan_hi;
`endif

  always_comb begin
    acc   = asi_valid & asi_ready_q;
    fwd   = acc & (asi_startofpacket | (state_q == ST_IN_PKT));
    drain = out_valid_q & axm_tready;

    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_sop_d    = out_sop_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_sop_d   = skid_sop_q;

    if (acc) begin
      if (asi_startofpacket) begin
        state_d = asi_endofpacket ? ST_IDLE : ST_IN_PKT;
      end else if (asi_endofpacket) begin
        state_d = ST_IDLE;
      end
    end

    // The output register refills from the skid entry first so order is preserved.
    if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        out_sop_d    = skid_sop_q;
        skid_valid_d = fwd;
        if (fwd) begin
          skid_data_d = beat_axi;
          skid_last_d = asi_endofpacket;
          skid_sop_d  = asi_startofpacket;
        end
      end else begin
        out_valid_d = fwd;
        if (fwd) begin
          out_data_d = beat_axi;
          out_last_d = asi_endofpacket;
          out_sop_d  = asi_startofpacket;
        end
      end
    end else if (fwd) begin
      skid_valid_d = 1'b1;
      skid_data_d  = beat_axi;
      skid_last_d  = asi_endofpacket;
      skid_sop_d   = asi_startofpacket;
    end

    asi_ready_d = !(out_valid_d && skid_valid_d);
  end

  always_ff @(posedge csi_clk or posedge rsi_reset) begin
    if (rsi_reset) begin
      state_q      <= ST_IDLE;
      asi_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_sop_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_sop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      asi_ready_q  <= asi_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_sop_q    <= out_sop_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      skid_sop_q   <= skid_sop_d;
    end
  end

  assign asi_ready  = asi_ready_q;
  assign axm_tvalid = out_valid_q;
  assign axm_tdata  = out_data_q;
  assign axm_tlast  = out_last_q;
  assign axm_tuser  = {{(TUSER_BITS-1){1'b0}}, out_sop_q};

endmodule

// File: tb/tb_oneapi_avs_to_axs_pixel_gasket.sv
// Bench for oneapi_avs_to_axs_pixel_gasket: directed cases plus random traffic against a queue-based reference model.
module tb_oneapi_avs_to_axs_pixel_gasket;

  logic         csi_clk = 1'b0;
  logic         rsi_reset = 1'b1;
  logic         asi_ready;
  logic         asi_valid = 1'b0;
  logic [191:0] asi_data = '0;
  logic         asi_startofpacket = 1'b0;
  logic         asi_endofpacket = 1'b0;
  logic [4:0]   asi_empty = '0;
  logic         axm_tready = 1'b1;
  logic         axm_tvalid;
  logic [159:0] axm_tdata;
  logic         axm_tlast;
  logic [19:0]  axm_tuser;

  oneapi_avs_to_axs_pixel_gasket dut (
    .csi_clk           (csi_clk),
    .rsi_reset         (rsi_reset),
    .asi_ready         (asi_ready),
    .asi_valid         (asi_valid),
    .asi_data          (asi_data),
    .asi_startofpacket (asi_startofpacket),
    .asi_endofpacket   (asi_endofpacket),
    .asi_empty         (asi_empty),
    .axm_tready        (axm_tready),
    .axm_tvalid        (axm_tvalid),
    .axm_tdata         (axm_tdata),
    .axm_tlast         (axm_tlast),
    .axm_tuser         (axm_tuser)
  );

  always #5 csi_clk = ~csi_clk;

  typedef struct {
    logic [159:0] data;
    logic         last;
    logic         sop;
  } beat_t;

  beat_t        exp_q[$];
  int           checks = 0;
  int           failures = 0;
  bit           in_pkt = 1'b0;
  bit           ready_low_pending = 1'b0;
  bit           rand_rdy = 1'b0;
  int           hold_cnt = 0;
  logic         stall_prev = 1'b0;
  logic [159:0] prev_data;
  logic         prev_last;
  logic [19:0]  prev_user;

  task automatic check_val(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected AXI beat straight from the channel rules: truncate (or saturate), pad, zero masked pixels.
  function automatic logic [159:0] ref_pixels(input logic [191:0] d, input logic eop, input logic [4:0] empty);
    logic [159:0] r;
    int nval;
    int ch;
    r = '0;
    nval = eop ? 4 - (int'(empty) * 8) / 48 : 4;
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 3; c++) begin
        ch = int'(d[p*48 + c*16 +: 16]);
`ifdef AVS_TO_AXS_SATURATE_EN
        if (ch > 4095) ch = 4095;
`else
        ch = ch % 4096;
`endif
        if (p < nval) r = r | (160'(ch) << (p*40 + c*12));
      end
    end
    return r;
  endfunction

  function automatic logic [191:0] pattern();
    logic [191:0] d;
    d = '0;
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 3; c++)
        d[p*48 + c*16 +: 16] = 16'(16*(p+1) + (c+1));
    return d;
  endfunction

  function automatic logic [191:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock: called just after a falling edge with inputs already driven.
  task automatic step();
    logic  acc;
    logic  drain;
    beat_t b;
    if (hold_cnt > 0) begin
      axm_tready = 1'b0;
      hold_cnt--;
    end else if (rand_rdy) begin
      axm_tready = ($urandom_range(0, 3) != 0);
    end else begin
      axm_tready = 1'b1;
    end
    #1;
    if (ready_low_pending) check_val("ready_after_reset", asi_ready, 0);
    else check_val("ready_vs_occupancy", asi_ready, exp_q.size() != 2);
    check_val("valid_vs_occupancy", axm_tvalid, exp_q.size() != 0);
    if (stall_prev)
      check_val("hold_while_stalled", {axm_tvalid, axm_tlast, axm_tuser, axm_tdata},
                {1'b1, prev_last, prev_user, prev_data});
    acc   = asi_valid & asi_ready;
    drain = axm_tvalid & axm_tready;
    if (drain) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_beat", axm_tvalid, 0);
      end else begin
        b = exp_q.pop_front();
        check_val("tdata", axm_tdata, b.data);
        check_val("tlast", axm_tlast, b.last);
        check_val("tuser", axm_tuser, {19'b0, b.sop});
      end
    end
    if (acc) begin
      if (asi_startofpacket || in_pkt) begin
        b.data = ref_pixels(asi_data, asi_endofpacket, asi_empty);
        b.last = asi_endofpacket;
        b.sop  = asi_startofpacket;
        exp_q.push_back(b);
      end
      if (asi_startofpacket) in_pkt = !asi_endofpacket;
      else if (asi_endofpacket) in_pkt = 1'b0;
    end
    stall_prev = axm_tvalid & !axm_tready;
    prev_data  = axm_tdata;
    prev_last  = axm_tlast;
    prev_user  = axm_tuser;
    ready_low_pending = 1'b0;
    @(posedge csi_clk);
    @(negedge csi_clk);
  endtask

  task automatic send_beat(input logic [191:0] d, input logic sop, input logic eop, input logic [4:0] empty);
    logic took;
    took = 1'b0;
    asi_valid = 1'b1;
    asi_data = d;
    asi_startofpacket = sop;
    asi_endofpacket = eop;
    asi_empty = empty;
    for (int i = 0; i < 50 && !took; i++) begin
      took = asi_ready;
      step();
    end
    if (!took) check_val("send_timeout", took, 1);
    asi_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    asi_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [191:0] d;
    repeat (2) @(negedge csi_clk);
    check_val("rst_ready", asi_ready, 0);
    check_val("rst_tvalid", axm_tvalid, 0);
    check_val("rst_tdata", axm_tdata, 0);
    check_val("rst_tlast", axm_tlast, 0);
    check_val("rst_tuser", axm_tuser, 0);
    rsi_reset = 1'b0;
    ready_low_pending = 1'b1;
    idle(2);

    // T1: single sop/eop beat, one cycle latency
    send_beat(pattern(), 1'b1, 1'b1, 5'd0);
    check_val("t1_tvalid", axm_tvalid, 1);
    check_val("t1_pix0", axm_tdata[39:0], 40'h0013012011);
    check_val("t1_pix3", axm_tdata[159:120], 40'h0043042041);
    check_val("t1_tuser", axm_tuser, 20'h00001);
    check_val("t1_tlast", axm_tlast, 1);
    idle(3);

    // T2: 3-beat packet under 4 cycles of back-pressure
    hold_cnt = 4;
    send_beat(pattern(), 1'b1, 1'b0, 5'd0);
    send_beat(rand_data(), 1'b0, 1'b0, 5'd0);
    check_val("t2_ready_low", asi_ready, 0);
    send_beat(rand_data(), 1'b0, 1'b1, 5'd0);
    idle(4);

    // T3: eop beat with empty=12 masks pixels 2 and 3
    send_beat(pattern(), 1'b1, 1'b1, 5'd12);
    check_val("t3_pix01", axm_tdata[79:0], 80'h00230220210013012011);
    check_val("t3_pix23", axm_tdata[159:80], 80'h0);
    check_val("t3_tlast", axm_tlast, 1);
    idle(3);

    // T4: beats without sop while idle are dropped
    send_beat(rand_data(), 1'b0, 1'b0, 5'd0);
    send_beat(rand_data(), 1'b0, 1'b1, 5'd3);
    check_val("t4_dropped", axm_tvalid, 0);
    send_beat(pattern(), 1'b1, 1'b1, 5'd0);
    check_val("t4_sop_out", {axm_tvalid, axm_tuser[0]}, 2'b11);
    idle(3);

    // T5: channel value 0x1234
    d = {12{16'h1234}};
    send_beat(d, 1'b1, 1'b1, 5'd0);
`ifdef AVS_TO_AXS_SATURATE_EN
    check_val("t5_chan", axm_tdata[11:0], 12'hFFF);
`else
    check_val("t5_chan", axm_tdata[11:0], 12'h234);
`endif
    check_val("t5_pad", axm_tdata[39:36], 4'h0);
    idle(3);

    // T6: reset with two beats buffered
    hold_cnt = 20;
    send_beat(pattern(), 1'b1, 1'b0, 5'd0);
    send_beat(rand_data(), 1'b0, 1'b0, 5'd0);
    #2 rsi_reset = 1'b1;
    #1;
    check_val("t6_tvalid", axm_tvalid, 0);
    check_val("t6_ready", asi_ready, 0);
    check_val("t6_tdata", axm_tdata, 0);
    exp_q.delete();
    in_pkt = 1'b0;
    stall_prev = 1'b0;
    hold_cnt = 0;
    @(negedge csi_clk);
    rsi_reset = 1'b0;
    ready_low_pending = 1'b1;
    send_beat(pattern(), 1'b1, 1'b0, 5'd0);
    send_beat(rand_data(), 1'b0, 1'b1, 5'd6);
    idle(4);

    // Random traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      asi_valid = ($urandom_range(0, 3) != 0);
      asi_data = rand_data();
      asi_startofpacket = ($urandom_range(0, 4) == 0);
      asi_endofpacket = ($urandom_range(0, 3) == 0);
      asi_empty = 5'($urandom_range(0, 31));
      step();
    end
    rand_rdy = 1'b0;
    idle(6);
    check_val("final_drained", axm_tvalid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
